s2mm_sts_gen: RTL and testbench

- Downstream companion of the AES datapath on the S2MM side. It monitors the handshakes on the S2MM data stream going to the DMA, counts the bytes in each packet and produces the AXI DMA S2MM status stream, which is currently tied to zero.
- For each completed packet it emits one 5-word status frame (app0..app4): app0 holds flags and a sequence number, app4 holds the received byte length.
- A small length FIFO decouples completed packets from status-stream backpressure.

---
 rtl/s2mm_sts_pkg.sv | 43 ++++
 rtl/sts_len_fifo.sv | 52 +++++
 rtl/s2mm_sts_gen.sv | 160 ++++++++++++++++
 tb/tb_s2mm_sts_gen.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/s2mm_sts_pkg.sv
// Shared constants, FSM encoding and status-entry layout for the S2MM status generator.
// The entry length field is sized for the widest supported byte counter.
package s2mm_sts_pkg;

    localparam int SEQ_W     = 16;
    localparam int LEN_MAX_W = 23;

    localparam logic [2:0] STS_WORD0    = 3'd0;
    localparam logic [2:0] STS_WORD1    = 3'd1;
    localparam logic [2:0] STS_WORD2    = 3'd2;
    localparam logic [2:0] STS_WORD3    = 3'd3;
    localparam logic [2:0] STS_WORD4    = 3'd4;
    localparam logic [2:0] STS_LAST_IDX = STS_WORD4;

    localparam int APP0_COMPLETE_BIT = 31;
    localparam int APP0_SAT_BIT      = 30;
    localparam int APP0_DROP_BIT     = 29;
    localparam int APP0_SEQ_MSB      = 15;
    localparam int APP0_SEQ_LSB      = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } sts_state_e;

    typedef struct packed {
        logic                 sat;
        logic [LEN_MAX_W-1:0] len;
        logic [SEQ_W-1:0]     seq;
    } sts_entry_t;

    function automatic logic [31:0] app0Word(input logic sat, input logic drop,
                                             input logic [SEQ_W-1:0] seq);
        logic [31:0] w;
        w = '0;
        w[APP0_COMPLETE_BIT]          = 1'b1;
        w[APP0_SAT_BIT]               = sat;
        w[APP0_DROP_BIT]              = drop;
        w[APP0_SEQ_MSB:APP0_SEQ_LSB]  = seq;
        return w;
    endfunction

endpackage

// File: rtl/sts_len_fifo.sv
// Show-ahead synchronous FIFO holding completed-packet entries; full and empty are registered.
// A push while full is still accepted when a pop happens in the same cycle.
module sts_len_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q, rdPtr_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic             full_q, empty_q;
    logic             doPush, doPop;

    assign doPush = push_i & (~full_q | pop_i);
    assign doPop  = pop_i & ~empty_q;
    assign cnt_d  = cnt_q + (AW+1)'(doPush) - (AW+1)'(doPop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
            if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == (AW+1)'(DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (doPush) mem_q[wrPtr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rdPtr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/s2mm_sts_gen.sv
// Watches the S2MM data handshakes, counts bytes per packet and emits one 5-word
// AXI DMA status frame per completed packet through a small length FIFO.
module s2mm_sts_gen
    import s2mm_sts_pkg::*;
#(
    parameter int C_S_AXIS_S2MM_TDATA_WIDTH     = 128,
    parameter int C_S_AXIS_S2MM_STS_TDATA_WIDTH = 32,
    parameter int C_LEN_WIDTH                   = 23,
    parameter int C_PKT_FIFO_DEPTH              = 4
) (
    input  logic                                       m_axi_s2mm_aclk,
    input  logic                                       rst,
    input  logic                                       mon_tvalid,
    input  logic                                       mon_tready,
    input  logic [C_S_AXIS_S2MM_TDATA_WIDTH/8-1:0]     mon_tkeep,
    input  logic                                       mon_tlast,
    output logic                                       pkt_hold,
    output logic [C_S_AXIS_S2MM_STS_TDATA_WIDTH-1:0]   s_axis_s2mm_sts_tdata,
    output logic [C_S_AXIS_S2MM_STS_TDATA_WIDTH/8-1:0] s_axis_s2mm_sts_tkeep,
    output logic                                       s_axis_s2mm_sts_tvalid,
    output logic                                       s_axis_s2mm_sts_tlast,
    input  logic                                       s_axis_s2mm_sts_tready,
    output logic                                       drop_err
);
    localparam int KEEP_W  = C_S_AXIS_S2MM_TDATA_WIDTH / 8;
    localparam int CNT_W   = $clog2(KEEP_W + 1);
    localparam int ENTRY_W = 1 + C_LEN_WIDTH + SEQ_W;

    logic                   beat, pktEnd;
    logic [CNT_W-1:0]       beatBytes;
    logic [C_LEN_WIDTH:0]   sum;
    logic [C_LEN_WIDTH-1:0] accSum;
    logic                   satSum;
    logic [C_LEN_WIDTH-1:0] acc_q, acc_d;
    logic                   sat_q, sat_d;
    logic [SEQ_W-1:0]       seq_q, seq_d;
    logic                   dropErr_q, dropErr_d;

    logic [ENTRY_W-1:0]     fifoHead;
    logic                   fifoFull, fifoEmpty, fifoPop;

    sts_state_e             state_q, state_d;
    logic [2:0]             idx_q, idx_d;
    sts_entry_t             entry_q, entry_d;
    logic                   entryDrop_q, entryDrop_d;
    logic [31:0]            stsWord;

    assign beat   = mon_tvalid & mon_tready;
    assign pktEnd = beat & mon_tlast;

    // Saturating byte accumulator; the closing beat's bytes belong to the entry being pushed.
    always_comb begin
        beatBytes = '0;
        for (int i = 0; i < KEEP_W; i++) beatBytes = beatBytes + CNT_W'(mon_tkeep[i]);
        sum    = {1'b0, acc_q} + (C_LEN_WIDTH+1)'(beatBytes);
        accSum = sum[C_LEN_WIDTH] ? '1 : sum[C_LEN_WIDTH-1:0];
        satSum = sat_q | sum[C_LEN_WIDTH];
        acc_d     = acc_q;
        sat_d     = sat_q;
        seq_d     = seq_q;
        dropErr_d = dropErr_q;
        if (pktEnd) begin
            acc_d = '0;
            sat_d = 1'b0;
            seq_d = seq_q + 16'd1;
            if (fifoFull && !fifoPop) dropErr_d = 1'b1;
        end else if (beat) begin
            acc_d = accSum;
            sat_d = satSum;
        end
    end

    sts_len_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (C_PKT_FIFO_DEPTH)
    ) u_len_fifo (
        .clk_i       (m_axi_s2mm_aclk),
        .rst_i       (rst),
        .push_i      (pktEnd),
        .push_data_i ({satSum, accSum, seq_q}),
        .pop_i       (fifoPop),
        .head_o      (fifoHead),
        .full_o      (fifoFull),
        .empty_o     (fifoEmpty)
    );

    // The drop flag is captured with the entry so word 0 stays stable while stalled.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        entry_d     = entry_q;
        entryDrop_d = entryDrop_q;
        fifoPop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifoEmpty) begin
                    entry_d.sat = fifoHead[ENTRY_W-1];
                    entry_d.len = LEN_MAX_W'(fifoHead[ENTRY_W-2 -: C_LEN_WIDTH]);
                    entry_d.seq = fifoHead[SEQ_W-1:0];
                    entryDrop_d = dropErr_q;
                    idx_d       = STS_WORD0;
                    state_d     = ST_SEND;
                end
            end
            ST_SEND: begin
                if (s_axis_s2mm_sts_tready) begin
                    if (idx_q == STS_LAST_IDX) begin
                        fifoPop = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge m_axi_s2mm_aclk) begin
        if (rst) begin
            acc_q       <= '0;
            sat_q       <= 1'b0;
            seq_q       <= '0;
            dropErr_q   <= 1'b0;
            state_q     <= ST_IDLE;
            idx_q       <= STS_WORD0;
            entry_q     <= '0;
            entryDrop_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            seq_q       <= seq_d;
            dropErr_q   <= dropErr_d;
            state_q     <= state_d;
            idx_q       <= idx_d;
            entry_q     <= entry_d;
            entryDrop_q <= entryDrop_d;
        end
    end

    always_comb begin
        stsWord = '0;
        if (state_q == ST_SEND) begin
            case (idx_q)
                STS_WORD0:                       stsWord = app0Word(entry_q.sat, entryDrop_q, entry_q.seq);
                STS_WORD1, STS_WORD2, STS_WORD3: stsWord = '0;
                STS_WORD4:                       stsWord = 32'(entry_q.len);
                default:                         stsWord = '0;
            endcase
        end
    end

    assign s_axis_s2mm_sts_tdata  = stsWord;
    assign s_axis_s2mm_sts_tkeep  = '1;
    assign s_axis_s2mm_sts_tvalid = (state_q == ST_SEND);
    assign s_axis_s2mm_sts_tlast  = (state_q == ST_SEND) && (idx_q == STS_LAST_IDX);
    assign pkt_hold               = fifoFull;
    assign drop_err               = dropErr_q;

endmodule

// File: tb/tb_s2mm_sts_gen.sv
// Scoreboard bench for s2mm_sts_gen: directed packets push expected status words,
// monitors pop and compare on every status handshake.
module tb_s2mm_sts_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        monTvalid, monTready, monTlast, sel8;
    logic [15:0] monTkeep;
    logic        stsTready;

    logic [31:0] stsTdata, stsTdata8;
    logic [3:0]  stsTkeep, stsTkeep8;
    logic        stsTvalid, stsTlast, pktHold, dropErr;
    logic        stsTvalid8, stsTlast8, pktHold8, dropErr8;

    logic [32:0] expQ[$];
    logic [32:0] expQ8[$];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    s2mm_sts_gen dut (
        .m_axi_s2mm_aclk        (clk),
        .rst                    (rst),
        .mon_tvalid             (monTvalid & ~sel8),
        .mon_tready             (monTready),
        .mon_tkeep              (monTkeep),
        .mon_tlast              (monTlast),
        .pkt_hold               (pktHold),
        .s_axis_s2mm_sts_tdata  (stsTdata),
        .s_axis_s2mm_sts_tkeep  (stsTkeep),
        .s_axis_s2mm_sts_tvalid (stsTvalid),
        .s_axis_s2mm_sts_tlast  (stsTlast),
        .s_axis_s2mm_sts_tready (stsTready),
        .drop_err               (dropErr)
    );

    s2mm_sts_gen #(.C_LEN_WIDTH(8)) dut8 (
        .m_axi_s2mm_aclk        (clk),
        .rst                    (rst),
        .mon_tvalid             (monTvalid & sel8),
        .mon_tready             (monTready),
        .mon_tkeep              (monTkeep),
        .mon_tlast              (monTlast),
        .pkt_hold               (pktHold8),
        .s_axis_s2mm_sts_tdata  (stsTdata8),
        .s_axis_s2mm_sts_tkeep  (stsTkeep8),
        .s_axis_s2mm_sts_tvalid (stsTvalid8),
        .s_axis_s2mm_sts_tlast  (stsTlast8),
        .s_axis_s2mm_sts_tready (1'b1),
        .drop_err               (dropErr8)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic pushPacket(input bit to8, input logic [15:0] seq, input logic sat,
                              input logic drop, input logic [31:0] len);
        logic [32:0] w [5];
        w[0] = {1'b0, 1'b1, sat, drop, 13'd0, seq};
        w[1] = 33'd0;
        w[2] = 33'd0;
        w[3] = 33'd0;
        w[4] = {1'b1, len};
        for (int i = 0; i < 5; i++) begin
            if (to8) expQ8.push_back(w[i]);
            else     expQ.push_back(w[i]);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] keep, input logic last);
        monTvalid = 1'b1;
        monTready = 1'b1;
        monTkeep  = keep;
        monTlast  = last;
        @(posedge clk);
        #1;
        monTvalid = 1'b0;
        monTlast  = 1'b0;
        monTkeep  = '0;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((expQ.size() != 0 || expQ8.size() != 0) && n < 500) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        checkOutput("drain_timeout", 64'(n >= 500), 64'd0);
    endtask

    // Main DUT monitor: compares accepted words and checks stability while stalled.
    logic        stalled = 1'b0;
    logic [32:0] heldWord;
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else if (stsTvalid === 1'b1) begin
            if (stalled) checkOutput("hold_stable", {31'd0, stsTlast, stsTdata}, {31'd0, heldWord});
            if (stsTready) begin
                checkOutput("sts_tkeep", 64'(stsTkeep), 64'hF);
                if (expQ.size() == 0) checkOutput("unexpected_word", {31'd0, stsTlast, stsTdata}, 64'hDEAD);
                else checkOutput("sts_word", {31'd0, stsTlast, stsTdata}, {31'd0, expQ.pop_front()});
                stalled = 1'b0;
            end else begin
                stalled  = 1'b1;
                heldWord = {stsTlast, stsTdata};
            end
        end else begin
            if (stalled) checkOutput("valid_dropped_in_stall", 64'(stsTvalid), 64'd1);
            stalled = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst && stsTvalid8 === 1'b1) begin
            if (expQ8.size() == 0) checkOutput("unexpected_word8", {31'd0, stsTlast8, stsTdata8}, 64'hDEAD);
            else checkOutput("sts_word8", {31'd0, stsTlast8, stsTdata8}, {31'd0, expQ8.pop_front()});
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        monTvalid = 1'b0; monTready = 1'b0; monTlast = 1'b0; monTkeep = '0;
        sel8 = 1'b0; stsTready = 1'b1; rst = 1'b1;

        // Reset state
        @(posedge clk);
        #1;
        checkOutput("rst_tvalid",  64'(stsTvalid), 64'd0);
        checkOutput("rst_tlast",   64'(stsTlast),  64'd0);
        checkOutput("rst_tdata",   64'(stsTdata),  64'd0);
        checkOutput("rst_pkthold", 64'(pktHold),   64'd0);
        checkOutput("rst_droperr", 64'(dropErr),   64'd0);
        resetDut();

        // Four full beats -> 64 bytes, word 0 two cycles after the tlast beat
        pushPacket(0, 16'd0, 1'b0, 1'b0, 32'd64);
        applyStimulus(16'hFFFF, 1'b0);
        applyStimulus(16'hFFFF, 1'b0);
        applyStimulus(16'hFFFF, 1'b0);
        applyStimulus(16'hFFFF, 1'b1);
        checkOutput("lat_n1_tvalid", 64'(stsTvalid), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("lat_n2_tvalid", 64'(stsTvalid), 64'd1);
        checkOutput("lat_n2_word0",  64'(stsTdata),  64'h8000_0000);
        waitDrain();

        // Partial keep on last beat, plus a non-beat (tready low) that must not count
        resetDut();
        pushPacket(0, 16'd0, 1'b0, 1'b0, 32'd40);
        pushPacket(0, 16'd1, 1'b0, 1'b0, 32'd16);
        monTvalid = 1'b1; monTready = 1'b0; monTkeep = 16'hFFFF; monTlast = 1'b1;
        @(posedge clk);
        #1;
        monTvalid = 1'b0; monTlast = 1'b0;
        applyStimulus(16'hFFFF, 1'b0);
        applyStimulus(16'hFFFF, 1'b0);
        applyStimulus(16'h00FF, 1'b1);
        applyStimulus(16'hFFFF, 1'b1);
        waitDrain();

        // Backpressure: FIFO fills, fifth packet dropped
        resetDut();
        stsTready = 1'b0;
        pushPacket(0, 16'd0, 1'b0, 1'b0, 32'd16);
        pushPacket(0, 16'd1, 1'b0, 1'b1, 32'd16);
        pushPacket(0, 16'd2, 1'b0, 1'b1, 32'd16);
        pushPacket(0, 16'd3, 1'b0, 1'b1, 32'd16);
        applyStimulus(16'hFFFF, 1'b1);
        applyStimulus(16'hFFFF, 1'b1);
        applyStimulus(16'hFFFF, 1'b1);
        checkOutput("hold_after3", 64'(pktHold), 64'd0);
        applyStimulus(16'hFFFF, 1'b1);
        checkOutput("hold_after4", 64'(pktHold), 64'd1);
        checkOutput("drop_after4", 64'(dropErr), 64'd0);
        applyStimulus(16'hFFFF, 1'b1);
        checkOutput("drop_after5", 64'(dropErr), 64'd1);
        checkOutput("hold_after5", 64'(pktHold), 64'd1);
        stsTready = 1'b1;
        waitDrain();
        checkOutput("hold_drained", 64'(pktHold), 64'd0);
        pushPacket(0, 16'd5, 1'b0, 1'b1, 32'd16);
        applyStimulus(16'hFFFF, 1'b1);
        waitDrain();

        // Random status backpressure, including a 1-byte and a zero-keep packet
        resetDut();
        stsTready = 1'b0;
        pushPacket(0, 16'd0, 1'b0, 1'b0, 32'd32);
        pushPacket(0, 16'd1, 1'b0, 1'b0, 32'd1);
        pushPacket(0, 16'd2, 1'b0, 1'b0, 32'd0);
        applyStimulus(16'hFFFF, 1'b0);
        applyStimulus(16'hFFFF, 1'b1);
        applyStimulus(16'h0001, 1'b1);
        applyStimulus(16'h0000, 1'b1);
        for (int i = 0; i < 60; i++) begin
            stsTready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        stsTready = 1'b1;
        waitDrain();

        // 8-bit length counter saturates
        resetDut();
        sel8 = 1'b1;
        pushPacket(1, 16'd0, 1'b1, 1'b0, 32'h0000_00FF);
        pushPacket(1, 16'd1, 1'b0, 1'b0, 32'd4);
        for (int i = 0; i < 19; i++) applyStimulus(16'hFFFF, 1'b0);
        applyStimulus(16'hFFFF, 1'b1);
        applyStimulus(16'h000F, 1'b1);
        waitDrain();
        sel8 = 1'b0;

        // Reset while word 2 of a frame is on the bus
        resetDut();
        stsTready = 1'b1;
        pushPacket(0, 16'd0, 1'b0, 1'b0, 32'd16);
        applyStimulus(16'hFFFF, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("mid_frame_tvalid", 64'(stsTvalid), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_tvalid",  64'(stsTvalid), 64'd0);
        checkOutput("midrst_tlast",   64'(stsTlast),  64'd0);
        checkOutput("midrst_droperr", 64'(dropErr),   64'd0);
        rst = 1'b0;
        expQ.delete();
        pushPacket(0, 16'd0, 1'b0, 1'b0, 32'd48);
        applyStimulus(16'hFFFF, 1'b0);
        applyStimulus(16'hFFFF, 1'b0);
        applyStimulus(16'hFFFF, 1'b1);
        waitDrain();

        checkOutput("queues_empty", 64'(expQ.size() + expQ8.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
